// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 host-side logic.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int PS2_DATA_BITS = 8;
    localparam int PS2_STOP_EDGE = 10;
    localparam int PS2_ACK_EDGE  = 11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer, stability filter and falling-edge detect for one
// open-drain PS/2 line. Idle bus level is high, so everything resets to 1.
module ps2_line_sync #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pin_i,
    output logic level_o,
    output logic fall_o
);

    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FW-1:0] CNT_LAST = FW'(FILTER_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          fall_q;
    logic [FW-1:0] cnt_q;

    // A new level is taken only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            fall_q  <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                fall_q  <= ~sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + FW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter; owns the bus while busy is high.
//
// state     | meaning
// IDLE      | waiting for tx_valid; lines released
// INHIBIT   | clock held low to abort any device activity
// REQ       | start bit driven, waiting for the first device clock fall
// SHIFT     | data, parity and stop bits updated after each clock fall
// ACK       | evaluate data level sampled at the eleventh fall
// WAIT_IDLE | waiting for both lines to return high
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int FRAME_TIMEOUT_CYCLES = 100000,
    parameter int FILTER_CYCLES        = 4
) (
    input  logic       clock,
    input  logic       anti_reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int CW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES, FRAME_TIMEOUT_CYCLES));
    localparam logic [CW-1:0] INH_LOAD   = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] START_LOAD = CW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_DATA_E = 4'(PS2_DATA_BITS);
    localparam logic [3:0]    PARITY_E    = 4'(PS2_DATA_BITS + 1);
    localparam logic [3:0]    STOP_E      = 4'(PS2_STOP_EDGE);
    localparam logic [3:0]    ACK_E       = 4'(PS2_ACK_EDGE);

    logic clk_level, clk_fall, data_level, data_fall_unused;

    ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_sync (
        .clk_i   (clock),
        .rst_ni  (anti_reset),
        .pin_i   (ps2_clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    ps2_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_sync (
        .clk_i   (clock),
        .rst_ni  (anti_reset),
        .pin_i   (ps2_data_in),
        .level_o (data_level),
        .fall_o  (data_fall_unused)
    );

    ps2_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    edge_q, edge_d, edge_n;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          ack_q, ack_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fail;

    assign edge_n = (edge_q == ACK_E) ? ACK_E : edge_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        data_d    = data_q;
        par_d     = par_q;
        ack_d     = ack_q;
        ready_d   = 1'b0;
        busy_d    = 1'b1;
        clk_oe_d  = 1'b0;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        fail      = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d    = 1'b0;
                ready_d   = 1'b1;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    data_d   = tx_data;
                    par_d    = ~^tx_data;
                    cnt_d    = INH_LOAD;
                    state_d  = INHIBIT;
                    clk_oe_d = 1'b1;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            INHIBIT: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d   = REQ;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = START_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            REQ: begin
                if (clk_fall) begin
                    state_d   = SHIFT;
                    edge_d    = 4'd1;
                    cnt_d     = FRAME_LOAD;
                    data_oe_d = ~data_q[0];
                end else if (cnt_q == '0) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (clk_fall) begin
                        edge_d = edge_n;
                        if (edge_n <= LAST_DATA_E) begin
                            data_oe_d = ~data_q[edge_q[2:0]];
                        end else if (edge_n == PARITY_E) begin
                            data_oe_d = ~par_q;
                        end else if (edge_n == STOP_E) begin
                            data_oe_d = 1'b0;
                        end else begin
                            state_d   = ACK;
                            ack_d     = data_level;
                            data_oe_d = 1'b0;
                        end
                    end
                end
            end
            ACK: begin
                data_oe_d = 1'b0;
                if (cnt_q == '0 || ack_q) begin
                    fail = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (clk_level && data_level) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    edge_d  = '0;
                end else if (cnt_q == '0) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Any timeout or missing ack releases the bus and reports immediately.
        if (fail) begin
            state_d   = IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            ready_d   = 1'b0;
            cnt_d     = '0;
            edge_d    = '0;
        end
    end

    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            edge_q    <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            ack_q     <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            data_q    <= data_d;
            par_q     <= par_d;
            ack_q     <= ack_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_error    = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// captured frames are compared with an odd-parity frame model.
module tb_ps2_host_tx;

    localparam int H        = 20;
    localparam int INHIBIT  = 5000;
    localparam int START_TO = 2000;

    logic       clock = 1'b0;
    logic       anti_reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES       (INHIBIT),
        .START_TIMEOUT_CYCLES (START_TO),
        .FRAME_TIMEOUT_CYCLES (100000),
        .FILTER_CYCLES        (4)
    ) dut (
        .clock       (clock),
        .anti_reset  (anti_reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    always #10 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int dev_pulse = 0;
    bit dev_abort = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (tx_done === 1'b1) done_cnt++;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_par(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    function automatic logic [10:0] model_frame(input logic [7:0] d);
        return {1'b1, model_par(d), d, 1'b0};
    endfunction

    // Device side: measure inhibit, clock 11 pulses, capture the line while clock is low.
    task automatic dev_frame(input bit do_ack, input int glitch_p, input int reset_p,
                             output logic [10:0] cap, output int inh);
        cap = '1;
        inh = 0;
        while (ps2_clk_oe === 1'b1 && inh < 10000) begin
            inh++;
            @(negedge clock);
        end
        cap[0] = ps2_data_in;
        repeat (2 * H) @(negedge clock);
        for (int p = 1; p <= 11; p++) begin
            dev_pulse = p;
            dev_clk = 1'b0;
            if (p == reset_p) begin
                repeat (H / 2) @(negedge clock);
                #3 anti_reset = 1'b0;
                #1;
                check("reset_async_clk_oe", ps2_clk_oe, 0);
                check("reset_async_data_oe", ps2_data_oe, 0);
                check("reset_async_done", tx_done, 0);
                dev_clk = 1'b1;
                dev_data = 1'b1;
                dev_abort = 1'b1;
                return;
            end
            repeat (H) @(negedge clock);
            if (p <= 10) cap[p] = ps2_data_in;
            dev_clk = 1'b1;
            if (p == glitch_p) begin
                repeat (10) @(negedge clock);
                dev_clk = 1'b0;
                repeat (2) @(negedge clock);
                dev_clk = 1'b1;
                repeat (H - 12) @(negedge clock);
            end else if (p == 10 && do_ack) begin
                repeat (H / 2) @(negedge clock);
                dev_data = 1'b0;
                repeat (H / 2) @(negedge clock);
            end else if (p < 11) begin
                repeat (H) @(negedge clock);
            end
        end
        dev_data = 1'b1;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit do_ack, input bit exp_err,
                             input bit exp_par, input int glitch_p, input int reset_p,
                             input int poke_p, input string tag);
        logic [10:0] cap;
        int inh, n, k, m;
        bit seen;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, " ready_before"}, tx_ready, 1);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        check({tag, " busy_after_accept"}, busy, 1);
        check({tag, " clk_oe_after_accept"}, ps2_clk_oe, 1);
        seen = 1'b0;
        dev_abort = 1'b0;
        dev_pulse = 0;
        k = 0;
        m = 0;
        fork
            dev_frame(do_ack, glitch_p, reset_p, cap, inh);
            begin
                while (!seen && !dev_abort && k < 20000) begin
                    @(negedge clock);
                    k++;
                    if (tx_done === 1'b1) begin
                        seen = 1'b1;
                        check({tag, " tx_error"}, tx_error, exp_err);
                        check({tag, " clk_oe_released"}, ps2_clk_oe, 0);
                        check({tag, " data_oe_released"}, ps2_data_oe, 0);
                        check({tag, " busy_at_done"}, busy, 0);
                        check({tag, " ready_at_done"}, tx_ready, 0);
                        @(negedge clock);
                        check({tag, " done_one_cycle"}, tx_done, 0);
                        check({tag, " ready_after_done"}, tx_ready, 1);
                    end
                end
            end
            begin
                if (poke_p > 0) begin
                    while (dev_pulse != poke_p && m < 20000) begin
                        @(negedge clock);
                        m++;
                    end
                    tx_data = 8'hAA;
                    tx_valid = 1'b1;
                    @(negedge clock);
                    tx_valid = 1'b0;
                end
            end
        join
        if (!dev_abort) begin
            check({tag, " done_seen"}, seen, 1);
            check({tag, " inhibit_len"}, inh, INHIBIT);
            check({tag, " start_bit"}, cap[0], 0);
            check({tag, " parity_bit"}, cap[9], exp_par);
            check({tag, " stop_bit"}, cap[10], 1);
            check({tag, " frame"}, cap, model_frame(d));
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         exp_par;
        bit         exp_err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n, t0, t1, dc;
        logic [7:0] r;

        repeat (2) @(negedge clock);
        check("reset tx_ready", tx_ready, 1);
        check("reset busy", busy, 0);
        check("reset clk_oe", ps2_clk_oe, 0);
        check("reset data_oe", ps2_data_oe, 0);
        check("reset tx_done", tx_done, 0);
        check("reset tx_error", tx_error, 0);
        anti_reset = 1'b1;
        repeat (5) @(negedge clock);

        vecs[0] = '{8'hF4, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hED, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 1'b1};
        for (int i = 5; i < 7; i++) begin
            r = 8'($urandom_range(0, 255));
            vecs[i] = '{r, 1'b1, model_par(r), 1'b0};
        end
        for (int i = 0; i < 7; i++)
            run_frame(vecs[i].data, vecs[i].ack, vecs[i].exp_err, vecs[i].exp_par,
                      0, 0, 0, $sformatf("vec%0d_%02h", i, vecs[i].data));

        dc = done_cnt;
        run_frame(8'h81, 1'b1, 1'b0, model_par(8'h81), 4, 0, 3, "ignore_glitch");
        check("ignore single_done", done_cnt, dc + 1);
        check("ignore idle_after", busy, 0);
        run_frame(8'hAA, 1'b1, 1'b0, model_par(8'hAA), 0, 0, 0, "aa_back_to_back");

        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        tx_data = 8'hF4;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && n < 10000) begin
            @(negedge clock);
            n++;
        end
        t0 = cyc;
        check("timeout req_entered", ps2_data_oe, 1);
        n = 0;
        while (tx_done !== 1'b1 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        t1 = cyc;
        check("timeout delay", t1 - t0, START_TO);
        check("timeout tx_error", tx_error, 1);
        check("timeout clk_oe", ps2_clk_oe, 0);
        check("timeout data_oe", ps2_data_oe, 0);
        repeat (3) @(negedge clock);

        dc = done_cnt;
        run_frame(8'hF4, 1'b1, 1'b0, 1'b0, 0, 5, 0, "reset_mid");
        repeat (3) @(negedge clock);
        anti_reset = 1'b1;
        @(negedge clock);
        check("reset_mid ready_after", tx_ready, 1);
        check("reset_mid busy_after", busy, 0);
        repeat (4) @(negedge clock);
        check("reset_mid no_done", done_cnt, dc);
        run_frame(8'hF4, 1'b1, 1'b0, 1'b0, 0, 0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
